// File: rtl/mbist_pkg.sv
// Shared types and March C- element tables for the MBIST controller.
// Six elements: (w0) up(r0,w1) up(r1,w0) dn(r0,w1) dn(r1,w0) (r0).
package mbist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    typedef enum logic [2:0] {
        E_W0,
        E_R0W1_UP,
        E_R1W0_UP,
        E_R0W1_DN,
        E_R1W0_DN,
        E_R0_FINAL
    } elem_e;

    localparam int unsigned NUM_ELEMS = 6;
    localparam int unsigned OP_ADDR_W = 16;

    // Per-element tables, indexed by elem_e; bits 7:6 are unused encodings.
    localparam logic [7:0] ELEM_DOWN   = 8'b0001_1000;
    localparam logic [7:0] ELEM_HAS_RD = 8'b0011_1110;
    localparam logic [7:0] ELEM_HAS_WR = 8'b0001_1111;
    localparam logic [7:0] ELEM_RD_ONE = 8'b0001_0100;
    localparam logic [7:0] ELEM_WR_ONE = 8'b0000_1010;

    // data is the background bit: 0 = all-zeros word, 1 = all-ones word.
    typedef struct packed {
        logic                 valid;
        logic                 is_write;
        logic [OP_ADDR_W-1:0] addr;
        logic                 data;
        elem_e                elem;
    } op_t;

    function automatic logic [1:0] elem_num_ops(elem_e e);
        return {1'b0, ELEM_HAS_RD[e]} + {1'b0, ELEM_HAS_WR[e]};
    endfunction

    // The read (if any) is op 0; the write follows it.
    function automatic op_t make_op(elem_e e, logic [OP_ADDR_W-1:0] addr, logic op);
        op_t o;
        o.valid    = 1'b1;
        o.is_write = ELEM_HAS_WR[e] & (op | ~ELEM_HAS_RD[e]);
        o.data     = o.is_write ? ELEM_WR_ONE[e] : ELEM_RD_ONE[e];
        o.addr     = addr;
        o.elem     = e;
        return o;
    endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Memory command/response bus between the MBIST controller and the memory model.
interface mbist_march_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  mem_write_read;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (output mem_write_read, mem_address, mem_wdata, input mem_rdata);
    modport slave  (input mem_write_read, mem_address, mem_wdata, output mem_rdata);
endinterface

// File: rtl/mbist_cmp.sv
// S2/S3 delay line, read-data comparator and saturating mismatch counter.
// Optional first-failure log under `MBIST_FAIL_LOG_EN`.
module mbist_cmp
    import mbist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  op_t                   op_in,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  pipe_busy,
    output logic                  fail,
`ifdef MBIST_FAIL_LOG_EN
    output logic [ADDR_WIDTH-1:0] first_fail_addr,
    output logic [2:0]            first_fail_elem,
    output logic [DATA_WIDTH-1:0] first_fail_rdata,
`endif
    output logic [CNT_WIDTH-1:0]  fail_count
);

    op_t                 s2_q, s3_q;
    logic                fail_q;
    logic [CNT_WIDTH-1:0] fail_count_q;
    logic                mismatch;
    logic                unused_s3;

    // rdata lines up with S3: read issued from S1 returns two cycles later.
    assign mismatch  = s3_q.valid && !s3_q.is_write && (rdata != {DATA_WIDTH{s3_q.data}});
    assign pipe_busy = s2_q.valid | s3_q.valid;
    assign unused_s3 = ^{s3_q.addr, s3_q.elem};

`ifdef MBIST_FAIL_LOG_EN
    logic [ADDR_WIDTH-1:0] ff_addr_q;
    logic [2:0]            ff_elem_q;
    logic [DATA_WIDTH-1:0] ff_rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            ff_addr_q  <= '0;
            ff_elem_q  <= '0;
            ff_rdata_q <= '0;
        end else if (mismatch && !fail_q) begin
            ff_addr_q  <= s3_q.addr[ADDR_WIDTH-1:0];
            ff_elem_q  <= s3_q.elem;
            ff_rdata_q <= rdata;
        end
    end

    assign first_fail_addr  = ff_addr_q;
    assign first_fail_elem  = ff_elem_q;
    assign first_fail_rdata = ff_rdata_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_q         <= '0;
            s3_q         <= '0;
            fail_q       <= 1'b0;
            fail_count_q <= '0;
        end else begin
            s2_q <= op_in;
            s3_q <= s2_q;
            if (clr) begin
                fail_q       <= 1'b0;
                fail_count_q <= '0;
            end else if (mismatch) begin
                fail_q <= 1'b1;
                if (fail_count_q != '1) fail_count_q <= fail_count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign fail       = fail_q;
    assign fail_count = fail_count_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller: op generator (S0/S1) feeding mbist_cmp (S2/S3).
// Optional first-failure log ports under `MBIST_FAIL_LOG_EN`.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [CNT_WIDTH-1:0]  fail_count,
`ifdef MBIST_FAIL_LOG_EN
    output logic [ADDR_WIDTH-1:0] first_fail_addr,
    output logic [2:0]            first_fail_elem,
    output logic [DATA_WIDTH-1:0] first_fail_rdata,
`endif
    mbist_march_ctrl_if.master    mem
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q;
    logic                  busy_q, done_q;
    elem_e                 cur_elem_q, nxt_elem;
    logic [ADDR_WIDTH-1:0] cur_addr_q, nxt_addr;
    logic                  cur_op_q, nxt_op;
    logic                  elem_end, cur_last, accept, cmp_busy;
    op_t                   s0_q, s1_q;
    logic                  unused_s1_addr;

    assign accept = ((state_q == IDLE) || (state_q == DONE)) && start;

    // Cursor = the op to load into S0 on the next RUN cycle.
    always_comb begin
        nxt_elem = cur_elem_q;
        nxt_addr = cur_addr_q;
        nxt_op   = 1'b0;
        elem_end = ELEM_DOWN[cur_elem_q] ? (cur_addr_q == '0) : (cur_addr_q == LAST_ADDR);
        cur_last = (cur_elem_q == E_R0_FINAL) && elem_end;
        if ((elem_num_ops(cur_elem_q) == 2'd2) && !cur_op_q) begin
            nxt_op = 1'b1;
        end else if (elem_end) begin
            nxt_elem = elem_e'(cur_elem_q + 3'd1);
            nxt_addr = ELEM_DOWN[nxt_elem] ? LAST_ADDR : '0;
        end else begin
            nxt_addr = ELEM_DOWN[cur_elem_q] ? cur_addr_q - ADDR_WIDTH'(1)
                                             : cur_addr_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cur_elem_q <= E_W0;
            cur_addr_q <= '0;
            cur_op_q   <= 1'b0;
            s0_q       <= '0;
            s1_q       <= '0;
        end else begin
            s1_q <= s0_q;
            s0_q <= '0;
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        state_q    <= RUN;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        // Op 0 goes straight into S0 on the accepting edge.
                        s0_q       <= make_op(E_W0, '0, 1'b0);
                        cur_elem_q <= E_W0;
                        cur_addr_q <= ADDR_WIDTH'(1);
                        cur_op_q   <= 1'b0;
                    end
                end
                RUN: begin
                    s0_q       <= make_op(cur_elem_q, OP_ADDR_W'(cur_addr_q), cur_op_q);
                    cur_elem_q <= nxt_elem;
                    cur_addr_q <= nxt_addr;
                    cur_op_q   <= nxt_op;
                    if (cur_last) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!s0_q.valid && !s1_q.valid && !cmp_busy) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Empty stages hold all-zero ops, so idle commands read address 0 with wdata 0.
    assign mem.mem_write_read = s1_q.is_write;
    assign mem.mem_address    = s1_q.addr[ADDR_WIDTH-1:0];
    assign mem.mem_wdata      = {DATA_WIDTH{s0_q.is_write & s0_q.data}};
    assign unused_s1_addr     = ^s1_q.addr;

    assign busy = busy_q;
    assign done = done_q;

    mbist_cmp #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cmp (
        .clk             (clk),
        .rst_n           (rst_n),
        .clr             (accept),
        .op_in           (s1_q),
        .rdata           (mem.mem_rdata),
        .pipe_busy       (cmp_busy),
        .fail            (fail),
`ifdef MBIST_FAIL_LOG_EN
        .first_fail_addr (first_fail_addr),
        .first_fail_elem (first_fail_elem),
        .first_fail_rdata(first_fail_rdata),
`endif
        .fail_count      (fail_count)
    );

endmodule
